// File: rtl/sap1_pkg.sv
// Shared SAP-1 controller definitions: opcodes, one-hot T-state encoding and control word layout.
package sap1_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    typedef struct packed {
        logic cp;
        logic ep;
        logic lm_n;
        logic ce_n;
        logic li_n;
        logic ei_n;
        logic la_n;
        logic ea;
        logic su;
        logic eu;
        logic lb_n;
        logic lo_n;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        cp:   1'b0,
        ep:   1'b0,
        lm_n: 1'b1,
        ce_n: 1'b1,
        li_n: 1'b1,
        ei_n: 1'b1,
        la_n: 1'b1,
        ea:   1'b0,
        su:   1'b0,
        eu:   1'b0,
        lb_n: 1'b1,
        lo_n: 1'b1
    };

endpackage

// File: rtl/sap1_ring_counter.sv
// Six-state one-hot T-state ring with freeze, early return to T1 and illegal-state recovery.
module sap1_ring_counter
    import sap1_pkg::*;
(
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       freeze_i,
    input  logic       early_end_i,
    output logic [5:0] t_state_o
);

    t_state_e state_q;
    t_state_e state_d;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= T1;
        end else begin
            state_q <= state_d;
        end
    end

    // Any non-one-hot pattern falls to the default arm, even while frozen.
    always_comb begin
        state_d = T1;
        case (state_q)
            T1, T2, T3, T4, T5, T6: begin
                if (freeze_i) begin
                    state_d = state_q;
                end else if (early_end_i) begin
                    state_d = T1;
                end else begin
                    case (state_q)
                        T1:      state_d = T2;
                        T2:      state_d = T3;
                        T3:      state_d = T4;
                        T4:      state_d = T5;
                        T5:      state_d = T6;
                        default: state_d = T1;
                    endcase
                end
            end
            default: state_d = T1;
        endcase
    end

    assign t_state_o = state_q;

endmodule

// File: rtl/sap1_controller.sv
// SAP-1 control sequencer: ring counter, opcode decode and sticky halt flag.
// Build option SAP1_VARIABLE_CYCLE_EN ends LDA/OUT/NOP after their last active T-state.
module sap1_controller
    import sap1_pkg::*;
#(
    parameter int unsigned OPCODE_W = 4
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    output logic                cp_o,
    output logic                ep_o,
    output logic                lm_n_o,
    output logic                ce_n_o,
    output logic                li_n_o,
    output logic                ei_n_o,
    output logic                la_n_o,
    output logic                ea_o,
    output logic                su_o,
    output logic                eu_o,
    output logic                lb_n_o,
    output logic                lo_n_o,
    output logic                halt_o,
    output logic [5:0]          t_state_o
);

    logic [3:0] op;
    logic [5:0] t_state;
    logic       halt_q;
    logic       early_end;
    ctrl_t      ctrl;

    assign op = 4'(opcode_i);

    sap1_ring_counter u_ring (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .freeze_i    (halt_q),
        .early_end_i (early_end),
        .t_state_o   (t_state)
    );

    // Halt is taken on the edge ending T4 of HLT; the ring then freezes at T5.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            halt_q <= 1'b0;
        end else if (t_state == T4 && op == OP_HLT) begin
            halt_q <= 1'b1;
        end
    end

`ifdef SAP1_VARIABLE_CYCLE_EN
    always_comb begin
        early_end = 1'b0;
        case (t_state)
            T4: begin
                if (op != OP_LDA && op != OP_ADD && op != OP_SUB && op != OP_HLT) begin
                    early_end = 1'b1;
                end
            end
            T5: begin
                if (op == OP_LDA) begin
                    early_end = 1'b1;
                end
            end
            default: early_end = 1'b0;
        endcase
    end
`else
    assign early_end = 1'b0;
`endif

    always_comb begin
        ctrl = CTRL_IDLE;
        if (!halt_q) begin
            case (t_state)
                T1: begin
                    ctrl.ep   = 1'b1;
                    ctrl.lm_n = 1'b0;
                end
                T2: begin
                    ctrl.cp = 1'b1;
                end
                T3: begin
                    ctrl.ce_n = 1'b0;
                    ctrl.li_n = 1'b0;
                end
                T4: begin
                    case (op)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            ctrl.ei_n = 1'b0;
                            ctrl.lm_n = 1'b0;
                        end
                        OP_OUT: begin
                            ctrl.ea   = 1'b1;
                            ctrl.lo_n = 1'b0;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    case (op)
                        OP_LDA: begin
                            ctrl.ce_n = 1'b0;
                            ctrl.la_n = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            ctrl.ce_n = 1'b0;
                            ctrl.lb_n = 1'b0;
                            ctrl.su   = (op == OP_SUB);
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    if (op == OP_ADD || op == OP_SUB) begin
                        ctrl.eu   = 1'b1;
                        ctrl.la_n = 1'b0;
                        ctrl.su   = (op == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign cp_o      = ctrl.cp;
    assign ep_o      = ctrl.ep;
    assign lm_n_o    = ctrl.lm_n;
    assign ce_n_o    = ctrl.ce_n;
    assign li_n_o    = ctrl.li_n;
    assign ei_n_o    = ctrl.ei_n;
    assign la_n_o    = ctrl.la_n;
    assign ea_o      = ctrl.ea;
    assign su_o      = ctrl.su;
    assign eu_o      = ctrl.eu;
    assign lb_n_o    = ctrl.lb_n;
    assign lo_n_o    = ctrl.lo_n;
    assign halt_o    = halt_q;
    assign t_state_o = t_state;

endmodule

// File: tb/tb_sap1_controller.sv
// Scoreboard bench for sap1_controller: directed per-cycle expectations plus bus/one-hot invariants.
module tb_sap1_controller;

    localparam int B_CP = 11, B_EP = 10, B_LM = 9, B_CE = 8, B_LI = 7, B_EI = 6;
    localparam int B_LA = 5,  B_EA = 4,  B_SU = 3, B_EU = 2, B_LB = 1, B_LO = 0;
    localparam logic [11:0] W_IDLE = 12'b0011_1110_0011;

    logic       clk_i = 1'b0;
    logic       rstn_i;
    logic [3:0] opcode_i;
    logic cp_o, ep_o, lm_n_o, ce_n_o, li_n_o, ei_n_o, la_n_o, ea_o, su_o, eu_o, lb_n_o, lo_n_o, halt_o;
    logic [5:0] t_state_o;

    typedef struct {
        string       tag;
        logic [5:0]  st;
        logic [11:0] w;
        logic        h;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    event chk_ev;

    sap1_controller #(.OPCODE_W(4)) dut (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .opcode_i  (opcode_i),
        .cp_o      (cp_o),
        .ep_o      (ep_o),
        .lm_n_o    (lm_n_o),
        .ce_n_o    (ce_n_o),
        .li_n_o    (li_n_o),
        .ei_n_o    (ei_n_o),
        .la_n_o    (la_n_o),
        .ea_o      (ea_o),
        .su_o      (su_o),
        .eu_o      (eu_o),
        .lb_n_o    (lb_n_o),
        .lo_n_o    (lo_n_o),
        .halt_o    (halt_o),
        .t_state_o (t_state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Hand-written control word per T-state (1..6) and opcode, straight from the opcode table.
    function automatic logic [11:0] exp_word(input int t, input logic [3:0] op);
        logic [11:0] w;
        w = W_IDLE;
        case (t)
            1: begin w[B_EP] = 1'b1; w[B_LM] = 1'b0; end
            2: w[B_CP] = 1'b1;
            3: begin w[B_CE] = 1'b0; w[B_LI] = 1'b0; end
            4: begin
                if (op == 4'h0 || op == 4'h1 || op == 4'h2) begin w[B_EI] = 1'b0; w[B_LM] = 1'b0; end
                if (op == 4'hE) begin w[B_EA] = 1'b1; w[B_LO] = 1'b0; end
            end
            5: begin
                if (op == 4'h0) begin w[B_CE] = 1'b0; w[B_LA] = 1'b0; end
                if (op == 4'h1 || op == 4'h2) begin w[B_CE] = 1'b0; w[B_LB] = 1'b0; w[B_SU] = (op == 4'h2); end
            end
            6: begin
                if (op == 4'h1 || op == 4'h2) begin w[B_EU] = 1'b1; w[B_LA] = 1'b0; w[B_SU] = (op == 4'h2); end
            end
            default: ;
        endcase
        return w;
    endfunction

    function automatic int instr_len(input logic [3:0] op);
`ifdef SAP1_VARIABLE_CYCLE_EN
        if (op == 4'h0) return 5;
        if (op == 4'h1 || op == 4'h2) return 6;
        return 4;
`else
        return 6;
`endif
    endfunction

    task automatic push_exp(input logic [5:0] st, input logic [11:0] w, input logic h, input string tag);
        exp_t e;
        e.tag = tag; e.st = st; e.w = w; e.h = h;
        sb.push_back(e);
    endtask

    task automatic push_cycle(input logic [5:0] st, input logic [11:0] w, input logic h, input string tag);
        push_exp(st, w, h, tag);
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_instr(input logic [3:0] op, input string tag);
        opcode_i = op;
        for (int t = 1; t <= instr_len(op); t++) begin
            push_cycle(6'b000001 << (t - 1), exp_word(t, op), 1'b0, $sformatf("%s_T%0d", tag, t));
        end
    endtask

    // Monitor: invariants every sample point, scoreboard pop when an expectation is queued.
    initial begin
        forever begin
            int   drivers;
            exp_t e;
            @(negedge clk_i or chk_ev);
            drivers = int'(ep_o) + int'(!ce_n_o) + int'(!ei_n_o) + int'(ea_o) + int'(eu_o);
            chk("bus_drivers_le1", 32'(drivers <= 1), 32'd1);
            chk("t_state_onehot", 32'($onehot(t_state_o)), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.tag, "_t_state"}, 32'(t_state_o), 32'(e.st));
                chk({e.tag, "_ctrl"}, 32'({cp_o, ep_o, lm_n_o, ce_n_o, li_n_o, ei_n_o,
                                           la_n_o, ea_o, su_o, eu_o, lb_n_o, lo_n_o}), 32'(e.w));
                chk({e.tag, "_halt"}, 32'(halt_o), 32'(e.h));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn_i   = 1'b0;
        opcode_i = 4'h0;
        @(posedge clk_i);
        #1;
        push_cycle(6'b000001, exp_word(1, 4'h0), 1'b0, "reset");
        rstn_i = 1'b1;

        run_instr(4'h0, "lda_a");
        run_instr(4'h0, "lda_b");
        run_instr(4'h1, "add");
        run_instr(4'h2, "sub");
        run_instr(4'hE, "out");
        run_instr(4'h5, "nop");
        run_instr(4'h0, "lda_c");

        // Asynchronous reset in the middle of T5 of ADD.
        opcode_i = 4'h1;
        for (int t = 1; t <= 4; t++) begin
            push_cycle(6'b000001 << (t - 1), exp_word(t, 4'h1), 1'b0, $sformatf("addrst_T%0d", t));
        end
        push_exp(6'b010000, exp_word(5, 4'h1), 1'b0, "addrst_T5");
        #6;
        rstn_i = 1'b0;
        #1;
        push_exp(6'b000001, exp_word(1, 4'h0), 1'b0, "addrst_async");
        ->chk_ev;
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;

        run_instr(4'h2, "sub_after_rst");

        // HLT: T1..T4 normal, then frozen at T5 with idle controls.
        opcode_i = 4'hF;
        for (int t = 1; t <= 4; t++) begin
            push_cycle(6'b000001 << (t - 1), exp_word(t, 4'hF), 1'b0, $sformatf("hlt_T%0d", t));
        end
        for (int i = 0; i < 20; i++) begin
            if (i == 5) opcode_i = 4'h0;
            push_cycle(6'b010000, W_IDLE, 1'b1, $sformatf("halted_%0d", i));
        end
        rstn_i = 1'b0;
        push_cycle(6'b000001, exp_word(1, 4'h0), 1'b0, "hlt_reset");
        rstn_i = 1'b1;

        run_instr(4'h0, "lda_after_hlt");
        run_instr(4'hE, "out_b");
        run_instr(4'h1, "add_b");

        for (int i = 0; i < 1000; i++) begin
            opcode_i = 4'($urandom_range(0, 14));
            @(posedge clk_i);
            #1;
        end

        @(posedge clk_i);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
